// File: rtl/vtg_pattern_gen.sv
// Video timing and test-pattern generator: programmable DVI-style timing, pixel-enable divider,
// four test patterns, start-of-frame strobe and completed-frame counter.
module vtg_pattern_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned CNT_W    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        pix_ce,
  output logic [23:0] rgb,
  output logic        rgb_de,
  output logic        hsync,
  output logic        vsync,
  output logic        sof,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_ce_q, pix_ce_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [23:0]      solid_q, solid_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d;
  logic [15:0]      frame_q, frame_d;

  logic        first_px, active, h_win, v_win;
  logic [1:0]  mode_eff;
  logic [23:0] solid_eff, bar_rgb, pat_rgb;
  logic [2:0]  bar_idx;

  // Divider: pix_ce is registered so it reads 0 while in reset even for CLK_DIV=1.
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pix_ce_d = (div_d == DIV_LAST);
  end

  // Shadows are loaded on the (0,0) tick; that pixel already uses the freshly sampled values.
  always_comb begin
    first_px  = (hcnt_q == '0) && (vcnt_q == '0);
    mode_eff  = first_px ? mode : mode_q;
    solid_eff = first_px ? solid_rgb : solid_q;
    active    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    h_win     = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    v_win     = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
  end

  // Bar index = min(hcnt / BAR_W, 7) via threshold compares instead of a divider.
  always_comb begin
    bar_idx = '0;
    for (int unsigned b = 1; b < 8; b++) begin
      if (hcnt_q >= CNT_W'(b * BAR_W)) bar_idx = 3'(b);
    end
  end

  always_comb begin
    unique case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    unique case (mode_eff)
      2'b00:   pat_rgb = bar_rgb;
      2'b01:   pat_rgb = {3{hcnt_q[7:0]}};
      2'b10:   pat_rgb = solid_eff;
      default: pat_rgb = (hcnt_q[5] ^ vcnt_q[5]) ? 24'h000000 : 24'hFFFFFF;
    endcase
  end

  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    mode_d  = mode_q;
    solid_d = solid_q;
    rgb_d   = rgb_q;
    de_d    = de_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    sof_d   = sof_q;
    frame_d = frame_q;
    if (pix_ce_q) begin
      if (!en) begin
        hcnt_d  = '0;
        vcnt_d  = '0;
        mode_d  = '0;
        solid_d = '0;
        rgb_d   = '0;
        de_d    = 1'b0;
        hs_d    = ~HS_POL;
        vs_d    = ~VS_POL;
        sof_d   = 1'b0;
      end else begin
        rgb_d = active ? pat_rgb : 24'h0;
        de_d  = active;
        hs_d  = h_win ? HS_POL : ~HS_POL;
        vs_d  = v_win ? VS_POL : ~VS_POL;
        sof_d = first_px;
        if (first_px) begin
          mode_d  = mode;
          solid_d = solid_rgb;
        end
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          if (vcnt_q == V_LAST) begin
            vcnt_d  = '0;
            frame_d = frame_q + 16'd1;
          end else begin
            vcnt_d = vcnt_q + CNT_W'(1);
          end
        end else begin
          hcnt_d = hcnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      mode_q   <= '0;
      solid_q  <= '0;
      rgb_q    <= '0;
      de_q     <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      sof_q    <= 1'b0;
      frame_q  <= '0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      mode_q   <= mode_d;
      solid_q  <= solid_d;
      rgb_q    <= rgb_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      sof_q    <= sof_d;
      frame_q  <= frame_d;
    end
  end

  assign pix_ce    = pix_ce_q;
  assign rgb       = rgb_q;
  assign rgb_de    = de_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;
  assign sof       = sof_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vtg_pattern_gen.sv
// Bench for vtg_pattern_gen: two small-geometry instances (CLK_DIV=1 active-low syncs,
// CLK_DIV=3 active-high syncs) checked every clk against a pixel-index reference model.
module tb_vtg_pattern_gen;

  localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en;
  logic [1:0]  mode;
  logic [23:0] solid;

  logic        pce_o [2];
  logic [23:0] rgb_o [2];
  logic        de_o  [2];
  logic        hs_o  [2];
  logic        vs_o  [2];
  logic        sof_o [2];
  logic [15:0] fr_o  [2];

  vtg_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .CNT_W(12)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid),
    .pix_ce(pce_o[0]), .rgb(rgb_o[0]), .rgb_de(de_o[0]), .hsync(hs_o[0]),
    .vsync(vs_o[0]), .sof(sof_o[0]), .frame_cnt(fr_o[0])
  );

  vtg_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(3), .CNT_W(12)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid),
    .pix_ce(pce_o[1]), .rgb(rgb_o[1]), .rgb_de(de_o[1]), .hsync(hs_o[1]),
    .vsync(vs_o[1]), .sof(sof_o[1]), .frame_cnt(fr_o[1])
  );

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model state: clk edges since reset, linear pixel index since (re)start.
  int          m_edges [2];
  int          m_pix   [2];
  int          m_frame [2];
  logic [1:0]  m_mode  [2];
  logic [23:0] m_solid [2];
  logic        x_pce   [2];
  logic [23:0] x_rgb   [2];
  logic        x_de    [2];
  logic        x_hs    [2];
  logic        x_vs    [2];
  logic        x_sof   [2];

  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pattern(input logic [1:0] m, input logic [23:0] s,
                                          input int h, input int v);
    int idx;
    logic [7:0] g;
    case (m)
      2'd0: begin
        idx = h / (HA / 8);
        if (idx > 7) idx = 7;
        return bar_colour(idx);
      end
      2'd1: begin
        g = 8'(h % 256);
        return {g, g, g};
      end
      2'd2: return s;
      default: return (((h / 32) + (v / 32)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic idle_outputs(input int d, input logic pol);
    x_rgb[d] = '0;
    x_de[d]  = 1'b0;
    x_hs[d]  = ~pol;
    x_vs[d]  = ~pol;
    x_sof[d] = 1'b0;
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int   dv;
      int   h, v;
      logic pol;
      bit   tick;
      dv  = (d == 0) ? 1 : 3;
      pol = (d == 1);
      if (!rst_n) begin
        m_edges[d] = 0;
        m_pix[d]   = 0;
        m_frame[d] = 0;
        m_mode[d]  = '0;
        m_solid[d] = '0;
        x_pce[d]   = 1'b0;
        idle_outputs(d, pol);
      end else begin
        m_edges[d]++;
        tick = (m_edges[d] >= 2) && (((m_edges[d] - 1) % dv) == dv - 1);
        if (tick) begin
          if (!en) begin
            m_pix[d] = 0;
            idle_outputs(d, pol);
          end else begin
            h = m_pix[d] % HT;
            v = m_pix[d] / HT;
            if (h == 0 && v == 0) begin
              m_mode[d]  = mode;
              m_solid[d] = solid;
            end
            x_de[d]  = (h < HA) && (v < VA);
            x_rgb[d] = x_de[d] ? pattern(m_mode[d], m_solid[d], h, v) : 24'h0;
            x_hs[d]  = (h >= HA + HF && h < HA + HF + HSW) ? pol : ~pol;
            x_vs[d]  = (v >= VA + VF && v < VA + VF + VSW) ? pol : ~pol;
            x_sof[d] = (h == 0 && v == 0);
            if (h == HT - 1 && v == VT - 1) m_frame[d] = (m_frame[d] + 1) % 65536;
            m_pix[d] = (m_pix[d] + 1) % (HT * VT);
          end
        end
        x_pce[d] = ((m_edges[d] % dv) == dv - 1);
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, d, got, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk("pix_ce", d, 32'(pce_o[d]), 32'(x_pce[d]));
      chk("rgb", d, 32'(rgb_o[d]), 32'(x_rgb[d]));
      chk("rgb_de", d, 32'(de_o[d]), 32'(x_de[d]));
      chk("hsync", d, 32'(hs_o[d]), 32'(x_hs[d]));
      chk("vsync", d, 32'(vs_o[d]), 32'(x_vs[d]));
      chk("sof", d, 32'(sof_o[d]), 32'(x_sof[d]));
      chk("frame_cnt", d, 32'(fr_o[d]), 32'(m_frame[d]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int r, hold, waited;
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    solid = 24'h0;
    repeat (3) step();
    chk("reset_rgb", 0, 32'(rgb_o[0]), 32'h0);
    chk("reset_hsync_low_pol", 0, 32'(hs_o[0]), 32'h1);
    chk("reset_vsync_high_pol", 1, 32'(vs_o[1]), 32'h0);
    chk("reset_pix_ce", 0, 32'(pce_o[0]), 32'h0);

    // Two full frames of colour bars on the CLK_DIV=1 instance.
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2 * HT * VT + 2) step();
    chk("two_frames", 0, 32'(fr_o[0]), 32'd2);

    // Mid-frame switch to solid colour.
    repeat (60) step();
    mode  = 2'd2;
    solid = 24'h123456;
    repeat (500) step();

    // Drop en for 10 clk.
    en = 1'b0;
    repeat (10) step();
    chk("idle_de", 0, 32'(de_o[0]), 32'h0);
    chk("idle_hsync", 1, 32'(hs_o[1]), 32'h0);
    en = 1'b1;
    repeat (300) step();

    // Randomized run: pattern changes, short en drops, occasional reset.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 10) begin
        mode  = 2'($urandom_range(0, 3));
        solid = 24'($urandom);
      end else if (r < 14 && hold == 0) begin
        en   = 1'b0;
        hold = int'($urandom_range(1, 15));
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) en = 1'b1;
      end
      rst_n = (r != 999);
      step();
    end
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = 2'd0;
    repeat (5) step();

    // Reset while hsync is asserted on the CLK_DIV=1 instance.
    waited = 0;
    while (hs_o[0] !== 1'b0 && waited < 200) begin
      step();
      waited++;
    end
    chk("hsync_pulse_found", 0, 32'(hs_o[0]), 32'h0);
    rst_n = 1'b0;
    step();
    chk("rst_in_hsync_hs", 0, 32'(hs_o[0]), 32'h1);
    chk("rst_in_hsync_de", 0, 32'(de_o[0]), 32'h0);
    chk("rst_in_hsync_rgb", 0, 32'(rgb_o[0]), 32'h0);
    rst_n = 1'b1;
    repeat (2 * HT + 4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
